// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard controller:
// forwarding selects, FSM states and the all-idle control bundle.
package ex_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic bubble_ex_mem;
        logic mc_start;
    } hz_t;

    // Pipeline control bundle that neither holds nor clears anything.
    localparam hz_t HZ_NOP = '0;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// master = pipeline side, slave = ex_hazard_ctrl.
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_addr_IF;
    logic [4:0]       rs2_addr_IF;
    logic [4:0]       rs1_addr_ID;
    logic [4:0]       rs2_addr_ID;
    logic [4:0]       reg_wb_addr_ID;
    logic             ctrl_mem_r_ID;
    logic             mc_op_ID;
    logic [4:0]       reg_wb_addr_EX;
    logic             ctrl_reg_write_EX;
    logic [4:0]       reg_wb_addr_MEM;
    logic             ctrl_reg_write_MEM;
    logic             pc_branch_EX;
    logic             pc_jump_EX;
    logic             mc_done;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall_pc;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             stall_id_ex;
    logic             flush_id_ex;
    logic             bubble_ex_mem;
    logic             mc_start;
    logic             mc_busy;
    logic             mc_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_addr_IF, rs2_addr_IF, rs1_addr_ID, rs2_addr_ID,
        output reg_wb_addr_ID, ctrl_mem_r_ID, mc_op_ID,
        output reg_wb_addr_EX, ctrl_reg_write_EX,
        output reg_wb_addr_MEM, ctrl_reg_write_MEM,
        output pc_branch_EX, pc_jump_EX, mc_done,
        input  fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id,
        input  flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_mem,
        input  mc_start, mc_busy, mc_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_addr_IF, rs2_addr_IF, rs1_addr_ID, rs2_addr_ID,
        input  reg_wb_addr_ID, ctrl_mem_r_ID, mc_op_ID,
        input  reg_wb_addr_EX, ctrl_reg_write_EX,
        input  reg_wb_addr_MEM, ctrl_reg_write_MEM,
        input  pc_branch_EX, pc_jump_EX, mc_done,
        output fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id,
        output flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_mem,
        output mc_start, mc_busy, mc_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Per-operand forwarding compare; the younger EX/MEM result
// wins over MEM/WB, and x0 is never forwarded.
module fwd_unit
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_ex,
    input  logic       we_ex,
    input  logic [4:0] rd_mem,
    input  logic       we_mem,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (rs != 5'd0) begin
            if (we_ex && rd_ex == rs)
                sel = FWD_EX;
            else if (we_mem && rd_mem == rs)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: forwarding, load-use/redirect hazards,
// multi-cycle unit start/done FSM and perf counters.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst,
    ex_hazard_ctrl_if.slave hz
);

    localparam int TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

    logic [0:0]       state;
    logic [TMO_W-1:0] tmo;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       a_sel;
    logic [1:0]       b_sel;
    logic             redirect;
    logic             load_use;
    logic             redirect_taken;
    hz_t              ctl;

    fwd_unit u_fwd_a (
        .rs     (hz.rs1_addr_ID),
        .rd_ex  (hz.reg_wb_addr_EX),
        .we_ex  (hz.ctrl_reg_write_EX),
        .rd_mem (hz.reg_wb_addr_MEM),
        .we_mem (hz.ctrl_reg_write_MEM),
        .sel    (a_sel)
    );

    fwd_unit u_fwd_b (
        .rs     (hz.rs2_addr_ID),
        .rd_ex  (hz.reg_wb_addr_EX),
        .we_ex  (hz.ctrl_reg_write_EX),
        .rd_mem (hz.reg_wb_addr_MEM),
        .we_mem (hz.ctrl_reg_write_MEM),
        .sel    (b_sel)
    );

    assign redirect = hz.pc_branch_EX | hz.pc_jump_EX;
    assign load_use = hz.ctrl_mem_r_ID
                    && hz.reg_wb_addr_ID != 5'd0
                    && (hz.reg_wb_addr_ID == hz.rs1_addr_IF
                     || hz.reg_wb_addr_ID == hz.rs2_addr_IF);

    always_comb begin
        ctl            = HZ_NOP;
        redirect_taken = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (hz.mc_op_ID) begin
                        ctl.mc_start      = 1'b1;
                        ctl.stall_pc      = 1'b1;
                        ctl.stall_if_id   = 1'b1;
                        ctl.stall_id_ex   = 1'b1;
                        ctl.bubble_ex_mem = 1'b1;
                    end else if (redirect) begin
                        ctl.flush_if_id = 1'b1;
                        ctl.flush_id_ex = 1'b1;
                        redirect_taken  = 1'b1;
                    end else if (load_use) begin
                        ctl.stall_pc    = 1'b1;
                        ctl.stall_if_id = 1'b1;
                        ctl.flush_id_ex = 1'b1;
                    end
                end
                BUSY: begin
                    // Release on done so EX/MEM captures the result.
                    if (!hz.mc_done) begin
                        ctl.stall_pc      = 1'b1;
                        ctl.stall_if_id   = 1'b1;
                        ctl.stall_id_ex   = 1'b1;
                        ctl.bubble_ex_mem = 1'b1;
                    end
                end
                default: ctl = HZ_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmo       <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hz.mc_op_ID) begin
                        state <= BUSY;
                        tmo   <= '0;
                    end
                end
                BUSY: begin
                    if (hz.mc_done) begin
                        state <= IDLE;
                    end else if (tmo == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ctl.stall_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect_taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.fwd_a_sel     = rst ? FWD_REG : a_sel;
    assign hz.fwd_b_sel     = rst ? FWD_REG : b_sel;
    assign hz.stall_pc      = ctl.stall_pc;
    assign hz.stall_if_id   = ctl.stall_if_id;
    assign hz.flush_if_id   = ctl.flush_if_id;
    assign hz.stall_id_ex   = ctl.stall_id_ex;
    assign hz.flush_id_ex   = ctl.flush_id_ex;
    assign hz.bubble_ex_mem = ctl.bubble_ex_mem;
    assign hz.mc_start      = ctl.mc_start;
    assign hz.mc_busy       = !rst && state == BUSY;
    assign hz.mc_err        = err;
    assign hz.stall_cnt     = stall_cnt;
    assign hz.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl with CNT_W=3, MC_TIMEOUT=8
// so saturation and timeout are reached in a few cycles.
module tb_ex_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_hazard_ctrl_if #(.CNT_W(3)) hz ();

    ex_hazard_ctrl #(
        .CNT_W      (3),
        .MC_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    // {stall_pc, stall_if_id, flush_if_id, stall_id_ex,
    //  flush_id_ex, bubble_ex_mem, mc_start}
    logic [6:0] hold;
    assign hold = {hz.stall_pc, hz.stall_if_id, hz.flush_if_id,
                   hz.stall_id_ex, hz.flush_id_ex, hz.bubble_ex_mem,
                   hz.mc_start};

    localparam logic [6:0] H_NONE  = 7'b0000000;
    localparam logic [6:0] H_LU    = 7'b1100100;
    localparam logic [6:0] H_RDIR  = 7'b0010100;
    localparam logic [6:0] H_START = 7'b1101011;
    localparam logic [6:0] H_BUSY  = 7'b1101010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs1_addr_IF        = 5'd0;
        hz.rs2_addr_IF        = 5'd0;
        hz.rs1_addr_ID        = 5'd0;
        hz.rs2_addr_ID        = 5'd0;
        hz.reg_wb_addr_ID     = 5'd0;
        hz.ctrl_mem_r_ID      = 1'b0;
        hz.mc_op_ID           = 1'b0;
        hz.reg_wb_addr_EX     = 5'd0;
        hz.ctrl_reg_write_EX  = 1'b0;
        hz.reg_wb_addr_MEM    = 5'd0;
        hz.ctrl_reg_write_MEM = 1'b0;
        hz.pc_branch_EX       = 1'b0;
        hz.pc_jump_EX         = 1'b0;
        hz.mc_done            = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        hz.ctrl_mem_r_ID      = 1'b1;
        hz.reg_wb_addr_ID     = 5'd3;
        hz.rs1_addr_IF        = 5'd3;
        hz.rs1_addr_ID        = 5'd4;
        hz.reg_wb_addr_EX     = 5'd4;
        hz.ctrl_reg_write_EX  = 1'b1;
        #2;
        checks++;
        if (hold !== H_NONE) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", hold, H_NONE);
        end
        checks++;
        if (hz.fwd_a_sel !== 2'b00) begin
            failures++;
            $display("FAIL reset_fwd got=%b exp=00", hz.fwd_a_sel);
        end
        tick();
        checks++;
        if ({hz.stall_cnt, hz.flush_cnt, hz.mc_err, hz.mc_busy} !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs got=%0d/%0d/%b/%b exp=0/0/0/0",
                     hz.stall_cnt, hz.flush_cnt, hz.mc_err, hz.mc_busy);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_forwarding();
        idle_inputs();
        hz.reg_wb_addr_EX     = 5'd5;
        hz.ctrl_reg_write_EX  = 1'b1;
        hz.reg_wb_addr_MEM    = 5'd5;
        hz.ctrl_reg_write_MEM = 1'b1;
        hz.rs1_addr_ID        = 5'd5;
        hz.rs2_addr_ID        = 5'd5;
        #1;
        checks++;
        if (hz.fwd_a_sel !== 2'b01) begin
            failures++;
            $display("FAIL fwd_ex_wins got=%b exp=01", hz.fwd_a_sel);
        end
        checks++;
        if (hz.fwd_b_sel !== 2'b01) begin
            failures++;
            $display("FAIL fwd_b_ex got=%b exp=01", hz.fwd_b_sel);
        end
        hz.ctrl_reg_write_EX = 1'b0;
        #1;
        checks++;
        if (hz.fwd_a_sel !== 2'b10) begin
            failures++;
            $display("FAIL fwd_mem got=%b exp=10", hz.fwd_a_sel);
        end
        hz.reg_wb_addr_EX  = 5'd9;
        hz.ctrl_reg_write_EX = 1'b1;
        hz.rs2_addr_ID     = 5'd9;
        #1;
        checks++;
        if ({hz.fwd_a_sel, hz.fwd_b_sel} !== 4'b1001) begin
            failures++;
            $display("FAIL fwd_split got=%b exp=1001",
                     {hz.fwd_a_sel, hz.fwd_b_sel});
        end
        hz.reg_wb_addr_EX  = 5'd0;
        hz.reg_wb_addr_MEM = 5'd0;
        hz.rs1_addr_ID     = 5'd0;
        hz.rs2_addr_ID     = 5'd0;
        #1;
        checks++;
        if ({hz.fwd_a_sel, hz.fwd_b_sel} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_x0 got=%b exp=0000",
                     {hz.fwd_a_sel, hz.fwd_b_sel});
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        hz.ctrl_mem_r_ID  = 1'b1;
        hz.reg_wb_addr_ID = 5'd7;
        hz.rs2_addr_IF    = 5'd7;
        #1;
        checks++;
        if (hold !== H_LU) begin
            failures++;
            $display("FAIL lu_hold got=%b exp=%b", hold, H_LU);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hold !== H_NONE) begin
            failures++;
            $display("FAIL lu_release got=%b exp=%b", hold, H_NONE);
        end
        checks++;
        if (hz.stall_cnt !== 3'd1) begin
            failures++;
            $display("FAIL lu_stall_cnt got=%0d exp=1", hz.stall_cnt);
        end
        hz.ctrl_mem_r_ID  = 1'b1;
        hz.reg_wb_addr_ID = 5'd0;
        hz.rs1_addr_IF    = 5'd0;
        #1;
        checks++;
        if (hold !== H_NONE) begin
            failures++;
            $display("FAIL lu_x0 got=%b exp=%b", hold, H_NONE);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        hz.ctrl_mem_r_ID  = 1'b1;
        hz.reg_wb_addr_ID = 5'd7;
        hz.rs2_addr_IF    = 5'd7;
        hz.pc_branch_EX   = 1'b1;
        #1;
        checks++;
        if (hold !== H_RDIR) begin
            failures++;
            $display("FAIL rdir_hold got=%b exp=%b", hold, H_RDIR);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({hz.flush_cnt, hz.stall_cnt} !== {3'd1, 3'd0}) begin
            failures++;
            $display("FAIL rdir_cnts got=%0d/%0d exp=1/0",
                     hz.flush_cnt, hz.stall_cnt);
        end
        hz.pc_jump_EX = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.flush_cnt !== 3'd7) begin
            failures++;
            $display("FAIL flush_sat got=%0d exp=7", hz.flush_cnt);
        end
    endtask

    task automatic test_mc_done();
        int stalls;
        do_reset();
        stalls = 0;
        hz.mc_op_ID = 1'b1;
        hz.mc_done  = 1'b1;
        #1;
        checks++;
        if (hold !== H_START) begin
            failures++;
            $display("FAIL mc_start_hold got=%b exp=%b", hold, H_START);
        end
        stalls += int'(hz.stall_pc);
        tick();
        hz.mc_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({hold, hz.mc_busy} !== {H_BUSY, 1'b1}) begin
                failures++;
                $display("FAIL mc_busy_hold cyc=%0d got=%b exp=%b1",
                         i, {hold, hz.mc_busy}, H_BUSY);
            end
            stalls += int'(hz.stall_pc);
            tick();
        end
        hz.mc_done = 1'b1;
        #1;
        checks++;
        if ({hold, hz.mc_busy} !== {H_NONE, 1'b1}) begin
            failures++;
            $display("FAIL mc_done_release got=%b exp=%b1",
                     {hold, hz.mc_busy}, H_NONE);
        end
        tick();
        hz.mc_op_ID = 1'b0;
        #1;
        checks++;
        if ({hz.stall_cnt, hz.mc_busy, stalls[2:0]} !== {3'd5, 1'b0, 3'd5}) begin
            failures++;
            $display("FAIL mc_done_cnt got=%0d busy=%b seen=%0d exp=5/0/5",
                     hz.stall_cnt, hz.mc_busy, stalls);
        end
        tick();
        #1;
        checks++;
        if ({hz.mc_busy, hold} !== {1'b0, H_NONE}) begin
            failures++;
            $display("FAIL mc_done_idle got=%b exp=0%b",
                     {hz.mc_busy, hold}, H_NONE);
        end
        hz.mc_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        hz.mc_op_ID = 1'b1;
        tick();
        hz.mc_done = 1'b1;
        tick();
        hz.mc_done = 1'b0;
        #1;
        checks++;
        if ({hz.mc_busy, hold} !== {1'b0, H_START}) begin
            failures++;
            $display("FAIL b2b_restart got=%b exp=0%b",
                     {hz.mc_busy, hold}, H_START);
        end
        tick();
        checks++;
        if ({hz.mc_busy, hold} !== {1'b1, H_BUSY}) begin
            failures++;
            $display("FAIL b2b_busy got=%b exp=1%b",
                     {hz.mc_busy, hold}, H_BUSY);
        end
        hz.mc_done = 1'b1;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic test_timeout();
        int busy_cycles;
        do_reset();
        busy_cycles = 0;
        hz.mc_op_ID = 1'b1;
        tick();
        hz.mc_op_ID = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (hz.mc_busy === 1'b1) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 8) begin
            failures++;
            $display("FAIL tmo_busy_cycles got=%0d exp=8", busy_cycles);
        end
        checks++;
        if ({hz.mc_err, hz.mc_busy} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_err got=err%b busy%b exp=err1 busy0",
                     hz.mc_err, hz.mc_busy);
        end
        checks++;
        if (hz.stall_cnt !== 3'd7) begin
            failures++;
            $display("FAIL stall_sat got=%0d exp=7", hz.stall_cnt);
        end
        hz.mc_op_ID = 1'b1;
        tick();
        hz.mc_op_ID = 1'b0;
        hz.mc_done  = 1'b1;
        tick();
        hz.mc_done  = 1'b0;
        tick();
        checks++;
        if ({hz.mc_err, hz.mc_busy} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_sticky got=err%b busy%b exp=err1 busy0",
                     hz.mc_err, hz.mc_busy);
        end
    endtask

    task automatic test_rst_mid_busy();
        do_reset();
        hz.mc_op_ID = 1'b1;
        tick();
        tick();
        checks++;
        if ({hz.mc_busy, hold} !== {1'b1, H_BUSY}) begin
            failures++;
            $display("FAIL rst_pre_busy got=%b exp=1%b",
                     {hz.mc_busy, hold}, H_BUSY);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({hz.mc_busy, hold, hz.stall_cnt} !== {1'b0, H_NONE, 3'd0}) begin
            failures++;
            $display("FAIL rst_mid_busy busy=%b hold=%b cnt=%0d exp=0/%b/0",
                     hz.mc_busy, hold, hz.stall_cnt, H_NONE);
        end
        tick();
        hz.mc_op_ID = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({hz.mc_busy, hz.mc_err} !== 2'b00) begin
            failures++;
            $display("FAIL rst_after got=%b exp=00", {hz.mc_busy, hz.mc_err});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect();
        test_mc_done();
        test_back_to_back();
        test_timeout();
        test_rst_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline sequencer for the EX stage of the 5-stage RV32 core.
- Generates operand-forwarding selects for the EX ALU inputs.
- Detects load-use hazards and redirects (branch/jump) and drives stall/flush of the PC, IF/ID, ID/EX and EX/MEM registers.
- Runs a start/done FSM that holds the pipeline while a multi-cycle arithmetic unit beside the ALU completes. It also keeps saturating stall/flush counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt
- MC_TIMEOUT, 64, max BUSY cycles before abort (must be ≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- rs1_addr_IF  in  5  rs1 of instruction in ID (IF/ID register)
- rs2_addr_IF  in  5  rs2 of instruction in ID
- rs1_addr_ID  in  5  rs1 of instruction in EX (ID/EX register)
- rs2_addr_ID  in  5  rs2 of instruction in EX
- reg_wb_addr_ID  in  5  rd of instruction in EX
- ctrl_mem_r_ID  in  1  instruction in EX is a load
- mc_op_ID  in  1  instruction in EX is a multi-cycle op
- reg_wb_addr_EX  in  5  rd in EX/MEM
- ctrl_reg_write_EX  in  1  EX/MEM writes rd
- reg_wb_addr_MEM  in  5  rd in MEM/WB
- ctrl_reg_write_MEM  in  1  MEM/WB writes rd
- pc_branch_EX  in  1  branch taken in EX
- pc_jump_EX  in  1  jump in EX
- mc_done  in  1  multi-cycle unit result valid
- fwd_a_sel  out  2  ALU rs1 source: 00 rd1_ID, 01 alu_out_EX, 10 WB data
- fwd_b_sel  out  2  same encoding for rs2
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID to NOP
- stall_id_ex  out  1  hold ID/EX
- flush_id_ex  out  1  clear ID/EX to NOP
- bubble_ex_mem  out  1  load NOP into EX/MEM
- mc_start  out  1  one-cycle start pulse to multi-cycle unit
- mc_busy  out  1  FSM in BUSY
- mc_err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset (async): state IDLE; timeout counter, stall_cnt, flush_cnt and mc_err are 0. While rst=1, all stall/flush/bubble/mc_start outputs are 0 and both fwd selects are 00.
- Forwarding (combinational, per operand, rs=x0 always 00):
  - Match reg_wb_addr_EX with ctrl_reg_write_EX → 01.
  - Otherwise match reg_wb_addr_MEM with ctrl_reg_write_MEM → 10.
  - Otherwise 00. EX beats MEM when both match.
- Load-use (IDLE only):
  - Condition: ctrl_mem_r_ID and reg_wb_addr_ID≠0 and (reg_wb_addr_ID==rs1_addr_IF or ==rs2_addr_IF).
  - Action: stall_pc=stall_if_id=1, flush_id_ex=1 for exactly one cycle.
- Redirect (IDLE only), when pc_branch_EX|pc_jump_EX:
  - flush_if_id=flush_id_ex=1 for the same cycle; flush_cnt increments.
  - Redirect overrides load-use, so no stall is raised that cycle.
- FSM states IDLE, BUSY:
  - IDLE & mc_op_ID:
    - mc_start=1 for that cycle.
    - stall_pc=stall_if_id=stall_id_ex=1 and bubble_ex_mem=1.
    - Next state BUSY; timeout counter cleared.
    - Redirect/load-use are not evaluated: a multi-cycle op is never a branch/jump or load.
  - BUSY & !mc_done:
    - Same four holds asserted; mc_busy=1.
    - Counter increments.
    - When counter reaches MC_TIMEOUT−1: mc_err←1, next state IDLE.
  - BUSY & mc_done:
    - All holds deasserted this cycle, so the EX/MEM register captures the result.
    - Next state IDLE.
  - mc_done is ignored in IDLE, including in the start cycle.
  - mc_err clears only on rst.
- Back-to-back multi-cycle ops: the second starts on the cycle after return to IDLE (1-cycle IDLE gap minimum).
- stall_cnt increments every cycle stall_pc=1. Both counters hold at 2^CNT_W−1.
- Reset asserted mid-BUSY: immediate return to IDLE. The multi-cycle unit is reset by the same rst.
- Latency: all hazard outputs are combinational from inputs and current state. Only state, counters and mc_err are registered.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_EX=2'b01, FWD_WB=2'b10
  - State encoding IDLE=1'b0, BUSY=1'b1
  - NOP definition used by the flush logic
- One natural sub-module: fwd_unit, the pure combinational per-operand forwarding compare, instantiated twice.

Test Plan:
- EX/MEM rd=5 write, MEM/WB rd=5 write, rs1_addr_ID=5 → fwd_a_sel=01; remove EX match → 10; rs1=0 with all matching → 00.
- Load to x7 in EX, rs2_addr_IF=7 → one cycle stall_pc=stall_if_id=flush_id_ex=1, stall_cnt=1, next cycle all 0.
- Same load-use plus pc_branch_EX=1 → flush_if_id=flush_id_ex=1, stall_pc=0, flush_cnt=1, stall_cnt=0.
- mc_op_ID=1, mc_done raised 4 cycles later → mc_start pulse once, stalls 5 cycles total, deasserted on the done cycle, stall_cnt=5, state IDLE.
- MC_TIMEOUT=8, mc_done never → mc_busy for 8 cycles, mc_err=1 sticky, FSM IDLE; assert rst mid-BUSY in a rerun → all outputs 0 immediately.
- CNT_W=3, stall 9 cycles → stall_cnt saturates at 7.
